// File: rtl/uram_arb_pkg.sv
// Shared types for the URAM port arbiter: tag carried down the read-latency
// pipeline, FSM state encoding and the read-latency helper.
package uram_arb_pkg;

  // Requester ids fit in 3 bits because NREQ is limited to 2..8.
  localparam int ID_W = 3;
  localparam int NBPIPE_DEF = 3;
  localparam int LAT = NBPIPE_DEF + 1;

  typedef struct packed {
    logic            is_read;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Command-to-dout latency of a wrapper built with the given output pipeline.
  function automatic int uram_lat(input int nbpipe);
    return nbpipe + 1;
  endfunction

endpackage

// File: rtl/uram_port_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter: grants the first request at or after the
// pointer; the pointer moves past the winner whenever update_i is high.
module rr_arbiter
  import uram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            update_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] grant_id_o,
  output logic            grant_valid_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  function automatic int wrapIdx(input int base, input int off);
    int sum;
    sum = base + off;
    return (sum >= N) ? sum - N : sum;
  endfunction

  always_comb begin
    grant_o       = '0;
    grant_id_o    = '0;
    grant_valid_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!grant_valid_o && req_i[wrapIdx(int'(ptr_q), off)]) begin
        grant_valid_o                       = 1'b1;
        grant_id_o                          = ID_W'(wrapIdx(int'(ptr_q), off));
        grant_o[wrapIdx(int'(ptr_q), off)]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i && grant_valid_o) begin
      ptr_d = (int'(grant_id_o) == N - 1) ? '0 : grant_id_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/uram_port_arbiter.sv
// Round-robin sharing of one UltraRAM port between NREQ requesters, with
// read-return routing and optional post-reset zero sweep. URAM_ARB_STATS_EN adds grant counters.
module uram_port_arbiter
  import uram_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int AWIDTH    = 12,
  parameter int DWIDTH    = 72,
  parameter int NBPIPE    = 3,
  parameter int INIT_ZERO = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ-1:0]        req_we_i,
  input  logic [NREQ*AWIDTH-1:0] req_addr_i,
  input  logic [NREQ*DWIDTH-1:0] req_wdata_i,
  output logic [NREQ-1:0]        resp_valid_o,
  output logic [DWIDTH-1:0]      resp_data_o,
  output logic                   init_done_o,
  output logic                   uram_en_o,
  output logic                   uram_we_o,
  output logic [AWIDTH-1:0]      uram_addr_o,
  output logic [DWIDTH-1:0]      uram_din_o,
  input  logic [DWIDTH-1:0]      uram_dout_i
`ifdef URAM_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0]     grant_cnt_o
`endif
);

  localparam int PIPE_LAT = uram_lat(NBPIPE);
  localparam state_t RESET_STATE = (INIT_ZERO != 0) ? INIT : RUN;

  state_t state_q, state_d;
  logic [AWIDTH:0]   initCnt_q, initCnt_d;
  logic              uramEn_q, uramEn_d;
  logic              uramWe_q, uramWe_d;
  logic [AWIDTH-1:0] uramAddr_q, uramAddr_d;
  logic [DWIDTH-1:0] uramDin_q, uramDin_d;
  logic [ID_W-1:0]   cmdId_q, cmdId_d;
  tag_t              tagPipe_q [PIPE_LAT];
  tag_t              tagIn_d;
  tag_t              tagOut;
  logic [NREQ-1:0]   respValid_q, respValid_d;
  logic [DWIDTH-1:0] respData_q, respData_d;

  logic              arbEn;
  logic [NREQ-1:0]   reqMasked;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grantId;
  logic              grantValid;

  // Requests are only visible to the arbiter while running and out of reset.
  assign arbEn     = (state_q == RUN) && !rst_i;
  assign reqMasked = req_valid_i & {NREQ{arbEn}};

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (reqMasked),
    .update_i      (1'b1),
    .grant_o       (grant),
    .grant_id_o    (grantId),
    .grant_valid_o (grantValid)
  );

  assign req_ready_o = grant;
  assign init_done_o = arbEn;

  always_comb begin
    state_d    = state_q;
    initCnt_d  = initCnt_q;
    uramEn_d   = 1'b0;
    uramWe_d   = 1'b0;
    uramAddr_d = uramAddr_q;
    uramDin_d  = uramDin_q;
    cmdId_d    = cmdId_q;
    case (state_q)
      INIT: begin
        // The top counter bit marks that the last address is already on the port.
        if (initCnt_q[AWIDTH]) begin
          state_d = RUN;
        end else begin
          uramEn_d   = 1'b1;
          uramWe_d   = 1'b1;
          uramAddr_d = initCnt_q[AWIDTH-1:0];
          uramDin_d  = '0;
          initCnt_d  = initCnt_q + (AWIDTH+1)'(1);
        end
      end
      RUN: begin
        if (grantValid) begin
          uramEn_d = 1'b1;
          cmdId_d  = grantId;
          for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              uramWe_d   = req_we_i[i];
              uramAddr_d = req_addr_i[i*AWIDTH +: AWIDTH];
              uramDin_d  = req_wdata_i[i*DWIDTH +: DWIDTH];
            end
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // The tag enters the pipeline alongside the command on the port, so its
  // tail lines up with the cycle the read data shows up on uram_dout_i.
  always_comb begin
    tagIn_d.is_read = uramEn_q && !uramWe_q;
    tagIn_d.id      = cmdId_q;
    tagOut          = tagPipe_q[PIPE_LAT-1];
    respValid_d     = '0;
    respData_d      = respData_q;
    if (tagOut.is_read) begin
      respData_d = uram_dout_i;
      for (int i = 0; i < NREQ; i++) begin
        if (int'(tagOut.id) == i) begin
          respValid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RESET_STATE;
      initCnt_q   <= '0;
      uramEn_q    <= 1'b0;
      uramWe_q    <= 1'b0;
      uramAddr_q  <= '0;
      uramDin_q   <= '0;
      cmdId_q     <= '0;
      respValid_q <= '0;
      respData_q  <= '0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        tagPipe_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      initCnt_q    <= initCnt_d;
      uramEn_q     <= uramEn_d;
      uramWe_q     <= uramWe_d;
      uramAddr_q   <= uramAddr_d;
      uramDin_q    <= uramDin_d;
      cmdId_q      <= cmdId_d;
      respValid_q  <= respValid_d;
      respData_q   <= respData_d;
      tagPipe_q[0] <= tagIn_d;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tagPipe_q[k] <= tagPipe_q[k-1];
      end
    end
  end

  assign uram_en_o    = uramEn_q;
  assign uram_we_o    = uramWe_q;
  assign uram_addr_o  = uramAddr_q;
  assign uram_din_o   = uramDin_q;
  assign resp_valid_o = respValid_q;
  assign resp_data_o  = respData_q;

`ifdef URAM_ARB_STATS_EN
  logic [31:0] grantCnt_q [NREQ];

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREQ; i++) begin
        grantCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && (grantCnt_q[i] != '1)) begin
          grantCnt_q[i] <= grantCnt_q[i] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : gen_cnt_out
    assign grant_cnt_o[g*32 +: 32] = grantCnt_q[g];
  end
`endif

endmodule
